// File: rtl/regfile_pkg.sv
// Shared types and default register indices for the parametrised KGP-RISC register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    WR_NONE   = 2'b00,
    WR_SINGLE = 2'b01,
    WR_PAIR   = 2'b10,
    WR_LINK   = 2'b11
  } wr_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_HI_REG   = 19;
  localparam int DEF_LO_REG   = 20;
  localparam int DEF_LINK_REG = 31;
  localparam int DEF_MON_REG  = 9;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reservations, cleared by writes.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W   = 5,
  parameter int HI_REG   = DEF_HI_REG,
  parameter int LO_REG   = DEF_LO_REG,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter int ZERO_R0  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              flush,
  input  wr_mode_t          wrMode,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic              rsvValid,
  input  logic [ADDR_W-1:0] rsvAddr,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic              busyA,
  output logic              busyB,
  output logic              clrHitA,
  output logic              clrHitB
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] setMask;
  logic [DEPTH-1:0] clrMask;

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (active) begin
      if (rsvValid && !(ZERO_R0 != 0 && rsvAddr == '0))
        setMask[rsvAddr] = 1'b1;
      case (wrMode)
        WR_SINGLE: clrMask[wrAddr] = 1'b1;
        WR_PAIR: begin
          clrMask[HI_REG] = 1'b1;
          clrMask[LO_REG] = 1'b1;
        end
        WR_LINK:   clrMask[LINK_REG] = 1'b1;
        default:   ;
      endcase
    end
  end

  // Set is OR'd after the clear so a same-cycle reservation wins over a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else if (flush)
      pending <= '0;
    else
      pending <= (pending & ~clrMask) | setMask;
  end

  assign busyA   = pending[rdAddrA];
  assign busyB   = pending[rdAddrB];
  assign clrHitA = clrMask[rdAddrA] & ~setMask[rdAddrA];
  assign clrHitB = clrMask[rdAddrB] & ~setMask[rdAddrB];

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with pair/link writes, pending scoreboard and soft-clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and pending clears to the read side.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int HI_REG   = DEF_HI_REG,
  parameter int LO_REG   = DEF_LO_REG,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter int MON_REG  = DEF_MON_REG,
  parameter int ZERO_R0  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic [1:0]        wr_mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] hi_data,
  input  logic [DATA_W-1:0] link_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] link_out,
  output logic [DATA_W-1:0] mon_out
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] HI_A   = ADDR_W'(HI_REG);
  localparam logic [ADDR_W-1:0] LO_A   = ADDR_W'(LO_REG);
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] MON_A  = ADDR_W'(MON_REG);

  wr_mode_t          wrMode;
  clr_state_t        state;
  clr_state_t        stateNext;
  logic [ADDR_W-1:0] clrIdx;
  logic [ADDR_W-1:0] clrIdxNext;
  logic              flush;
  logic              clrBusyQ;
  logic              bypassOn;
  logic              storedBusyA;
  logic              storedBusyB;
  logic              clrHitA;
  logic              clrHitB;
  logic [DATA_W-1:0] regs [DEPTH];

  assign wrMode = wr_mode_t'(wr_mode);

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_R0 != 0 && a == '0);
  endfunction

  // Stored value, optionally replaced by the write landing on this address at the next edge.
  function automatic logic [DATA_W-1:0] readPort(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              byp,
    input wr_mode_t          m,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] hd,
    input logic [DATA_W-1:0] ld
  );
    logic [DATA_W-1:0] r;
    r = stored;
    if (byp) begin
      case (m)
        WR_SINGLE: if (a == wa) r = wd;
        WR_PAIR: begin
          if (a == HI_A)      r = hd;
          else if (a == LO_A) r = wd;
        end
        WR_LINK:   if (a == LINK_A) r = ld;
        default:   ;
      endcase
    end
    if (!writable(a))
      r = '0;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clrIdx   <= '0;
      clrBusyQ <= 1'b0;
    end else begin
      state    <= stateNext;
      clrIdx   <= clrIdxNext;
      clrBusyQ <= (stateNext == CLEAR);
    end
  end

  // The sweep visits every index once; the last one also flushes the scoreboard.
  always_comb begin
    stateNext  = state;
    clrIdxNext = clrIdx;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          stateNext  = CLEAR;
          clrIdxNext = '0;
        end
      end
      CLEAR: begin
        clrIdxNext = clrIdx + 1'b1;
        if (clrIdx == {ADDR_W{1'b1}}) begin
          stateNext = IDLE;
          flush     = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clrIdx] <= '0;
    end else begin
      case (wrMode)
        WR_SINGLE: if (writable(wr_addr)) regs[wr_addr] <= wr_data;
        WR_PAIR: begin
          if (writable(HI_A)) regs[HI_A] <= hi_data;
          if (writable(LO_A)) regs[LO_A] <= wr_data;
        end
        WR_LINK:   if (writable(LINK_A)) regs[LINK_A] <= link_data;
        default:   ;
      endcase
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .HI_REG   (HI_REG),
    .LO_REG   (LO_REG),
    .LINK_REG (LINK_REG),
    .ZERO_R0  (ZERO_R0)
  ) uScoreboard (
    .clk      (clk),
    .rst      (rst),
    .active   (state == IDLE),
    .flush    (flush),
    .wrMode   (wrMode),
    .wrAddr   (wr_addr),
    .rsvValid (rsv_valid),
    .rsvAddr  (rsv_addr),
    .rdAddrA  (rd_addr_a),
    .rdAddrB  (rd_addr_b),
    .busyA    (storedBusyA),
    .busyB    (storedBusyB),
    .clrHitA  (clrHitA),
    .clrHitB  (clrHitB)
  );

`ifdef REGFILE_BYPASS_EN
  assign bypassOn = (state == IDLE) && !rst;
`else
  assign bypassOn = 1'b0;
`endif

  assign rd_data_a = readPort(rd_addr_a, regs[rd_addr_a], bypassOn, wrMode, wr_addr, wr_data, hi_data, link_data);
  assign rd_data_b = readPort(rd_addr_b, regs[rd_addr_b], bypassOn, wrMode, wr_addr, wr_data, hi_data, link_data);
  assign link_out  = readPort(LINK_A, regs[LINK_A], bypassOn, wrMode, wr_addr, wr_data, hi_data, link_data);
  assign mon_out   = readPort(MON_A, regs[MON_A], bypassOn, wrMode, wr_addr, wr_data, hi_data, link_data);

  assign busy_a   = storedBusyA & ~(bypassOn & clrHitA);
  assign busy_b   = storedBusyB & ~(bypassOn & clrHitB);
  assign clr_busy = clrBusyQ;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected values, a negedge monitor checks them.
module tb_regfile_mp;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data, hi_data, link_data, link_out, mon_out;
  logic        busy_a, busy_b, rsv_valid, clr_req, clr_busy;
  logic [1:0]  wr_mode;

  typedef enum int {S_RDA, S_RDB, S_BUSYA, S_BUSYB, S_CLRBUSY, S_LINK, S_MON} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] value;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .wr_mode   (wr_mode),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .hi_data   (hi_data),
    .link_data (link_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .link_out  (link_out),
    .mon_out   (mon_out)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] mode, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [31:0] hd, input logic [31:0] ld, input logic rv,
                               input logic [4:0] ra, input logic cr);
    wr_mode   = mode;
    wr_addr   = wa;
    wr_data   = wd;
    hi_data   = hd;
    link_data = ld;
    rsv_valid = rv;
    rsv_addr  = ra;
    clr_req   = cr;
  endtask

  task automatic idle();
    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic setReads(input logic [4:0] a, input logic [4:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input sel_t s, input logic [31:0] v, input string n);
    exp_t e;
    e.name  = n;
    e.sel   = s;
    e.value = v;
    expQ.push_back(e);
  endtask

  function automatic logic [31:0] sample(input sel_t s);
    case (s)
      S_RDA:     return rd_data_a;
      S_RDB:     return rd_data_b;
      S_BUSYA:   return {31'b0, busy_a};
      S_BUSYB:   return {31'b0, busy_b};
      S_CLRBUSY: return {31'b0, clr_busy};
      S_LINK:    return link_out;
      default:   return mon_out;
    endcase
  endfunction

  // Monitor: drains every expectation queued during the current cycle.
  initial begin
    exp_t e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e   = expQ.pop_front();
        got = sample(e.sel);
        checks++;
        if (got !== e.value) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.value);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle();
    setReads(5'd0, 5'd0);
    tick();
    setReads(5'd5, 5'd9);
    checkOutput(S_RDA, 32'h0, "reset_rdA");
    checkOutput(S_BUSYA, 32'h0, "reset_busyA");
    checkOutput(S_CLRBUSY, 32'h0, "reset_clrBusy");
    checkOutput(S_LINK, 32'h0, "reset_link");
    checkOutput(S_MON, 32'h0, "reset_mon");
    tick();
    rst = 1'b0;

    applyStimulus(WR_SINGLE, 5'd9, 32'h1234, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick(); idle(); setReads(5'd9, 5'd0);
    checkOutput(S_MON, 32'h1234, "single_mon");
    checkOutput(S_RDA, 32'h1234, "single_rdA");

    applyStimulus(WR_PAIR, 5'd0, 32'h5555, 32'hAAAA0000, 32'h0, 1'b0, 5'd0, 1'b0);
    tick(); idle(); setReads(5'd19, 5'd20);
    checkOutput(S_RDA, 32'hAAAA0000, "pair_hi");
    checkOutput(S_RDB, 32'h5555, "pair_lo");

    applyStimulus(WR_LINK, 5'd0, 32'h0, 32'h0, 32'hCAFE0001, 1'b0, 5'd0, 1'b0);
    tick(); idle(); setReads(5'd31, 5'd0);
    checkOutput(S_LINK, 32'hCAFE0001, "link_out");
    checkOutput(S_RDA, 32'hCAFE0001, "link_rdA");

    applyStimulus(WR_SINGLE, 5'd0, 32'hDEAD, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick(); idle(); setReads(5'd0, 5'd9);
    checkOutput(S_RDA, 32'h0, "r0_zero");
    checkOutput(S_RDB, 32'h1234, "r9_kept");

    applyStimulus(WR_SINGLE, 5'd4, 32'h1111, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(WR_SINGLE, 5'd4, 32'hBEEF, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    setReads(5'd4, 5'd4);
    checkOutput(S_RDA, BYP ? 32'hBEEF : 32'h1111, "bypass_same_cycle");
    tick(); idle();
    checkOutput(S_RDA, 32'hBEEF, "bypass_after_edge");
    applyStimulus(WR_SINGLE, 5'd9, 32'h9999, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput(S_MON, BYP ? 32'h9999 : 32'h1234, "bypass_mon");
    tick(); idle();
    checkOutput(S_MON, 32'h9999, "mon_after_edge");

    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0);
    setReads(5'd7, 5'd8);
    tick(); idle();
    checkOutput(S_BUSYA, 32'h1, "rsv_busy");
    checkOutput(S_BUSYB, 32'h0, "rsv_other_idle");
    applyStimulus(WR_SINGLE, 5'd7, 32'h77, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput(S_BUSYA, BYP ? 32'h0 : 32'h1, "busy_write_cycle");
    tick(); idle();
    checkOutput(S_BUSYA, 32'h0, "busy_cleared");
    checkOutput(S_RDA, 32'h77, "r7_written");
    applyStimulus(WR_SINGLE, 5'd7, 32'h78, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0);
    tick(); idle();
    checkOutput(S_BUSYA, 32'h1, "rsv_wins");
    checkOutput(S_RDA, 32'h78, "rsv_write_data");
    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0);
    tick(); idle(); setReads(5'd0, 5'd7);
    checkOutput(S_BUSYA, 32'h0, "rsv_r0_ignored");
    checkOutput(S_BUSYB, 32'h1, "r7_still_busy");

    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd19, 1'b0);
    tick();
    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd20, 1'b0);
    tick(); idle(); setReads(5'd19, 5'd20);
    checkOutput(S_BUSYA, 32'h1, "hi_busy");
    checkOutput(S_BUSYB, 32'h1, "lo_busy");
    applyStimulus(WR_PAIR, 5'd0, 32'h1, 32'h2, 32'h0, 1'b0, 5'd0, 1'b0);
    tick(); idle();
    checkOutput(S_BUSYA, 32'h0, "pair_clears_hi");
    checkOutput(S_BUSYB, 32'h0, "pair_clears_lo");
    checkOutput(S_RDA, 32'h2, "pair2_hi");
    checkOutput(S_RDB, 32'h1, "pair2_lo");
    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd31, 1'b0);
    tick();
    applyStimulus(WR_LINK, 5'd0, 32'h0, 32'h0, 32'h3131, 1'b0, 5'd0, 1'b0);
    tick(); idle(); setReads(5'd31, 5'd7);
    checkOutput(S_BUSYA, 32'h0, "link_clears");
    checkOutput(S_LINK, 32'h3131, "link2_out");

    for (int i = 0; i < 32; i++) begin
      applyStimulus(WR_SINGLE, 5'(i), 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd12, 1'b0);
    tick(); idle(); setReads(5'd12, 5'd31);
    checkOutput(S_BUSYA, 32'h1, "pre_sweep_busy");
    checkOutput(S_RDB, 32'hFFFFFFFF, "pre_sweep_fill");
    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
    tick(); idle();

    // After j sweep edges, registers 0..j-1 are clear and j..31 still hold the fill.
    for (int j = 0; j < 32; j++) begin
      setReads(5'(j), (j == 0) ? 5'd0 : 5'(j - 1));
      checkOutput(S_CLRBUSY, 32'h1, "sweep_clrBusy");
      checkOutput(S_RDA, (j == 0) ? 32'h0 : 32'hFFFFFFFF, "sweep_uncleared");
      checkOutput(S_RDB, 32'h0, "sweep_cleared");
      if (j == 5)
        applyStimulus(WR_SINGLE, 5'd3, 32'h3333, 32'h0, 32'h0, 1'b1, 5'd14, 1'b1);
      tick(); idle();
    end
    checkOutput(S_CLRBUSY, 32'h0, "sweep_done");
    for (int k = 0; k < 16; k++) begin
      setReads(5'(2 * k), 5'(2 * k + 1));
      checkOutput(S_RDA, 32'h0, "post_sweep_rdA");
      checkOutput(S_RDB, 32'h0, "post_sweep_rdB");
      checkOutput(S_BUSYA, 32'h0, "post_sweep_busyA");
      checkOutput(S_BUSYB, 32'h0, "post_sweep_busyB");
      tick();
    end

    applyStimulus(WR_SINGLE, 5'd5, 32'h55, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(WR_SINGLE, 5'd9, 32'h99, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(WR_SINGLE, 5'd15, 32'hF0F0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(WR_LINK, 5'd0, 32'h0, 32'h0, 32'h1357, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(WR_NONE, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
    tick(); idle();
    repeat (10) tick();
    setReads(5'd15, 5'd5);
    checkOutput(S_CLRBUSY, 32'h1, "pre_reset_clrBusy");
    checkOutput(S_RDA, 32'hF0F0, "pre_reset_r15");
    checkOutput(S_RDB, 32'h0, "pre_reset_r5");
    @(negedge clk);
    #1;
    rst = 1'b1;
    checkOutput(S_RDA, 32'h0, "mid_reset_r15");
    checkOutput(S_CLRBUSY, 32'h0, "mid_reset_clrBusy");
    checkOutput(S_LINK, 32'h0, "mid_reset_link");
    checkOutput(S_MON, 32'h0, "mid_reset_mon");
    checkOutput(S_BUSYA, 32'h0, "mid_reset_busy");
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();
    checkOutput(S_CLRBUSY, 32'h0, "after_reset_idle");
    checkOutput(S_RDA, 32'h0, "after_reset_r15");
    checkOutput(S_RDB, 32'h0, "after_reset_r5");
    applyStimulus(WR_SINGLE, 5'd6, 32'h66, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick(); idle(); setReads(5'd6, 5'd31);
    checkOutput(S_RDA, 32'h66, "post_reset_write");
    checkOutput(S_LINK, 32'h0, "post_reset_link");
    checkOutput(S_CLRBUSY, 32'h0, "post_reset_clrBusy");
    #1;
    checks++;
    if (rd_data_a !== 32'h66) begin
      errors++;
      $display("[TB] FAIL direct_r6: got %h expected %h", rd_data_a, 32'h66);
    end
    checks++;
    if (link_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL direct_link: got %h expected %h", link_out, 32'h0);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
